// File: rtl/or_sweep_if.sv
// or_sweep_if: stimulus/result bundle between the OR-gate sweep sequencer
// and the bench or DUT harness. The sequencer uses the master modport.
`timescale 1ns/1ps
interface or_sweep_if #(
  parameter int WIDTH = 10,
  parameter int ERR_W = 11
);
  logic             start;
  logic [0:WIDTH-1] idata;
  logic             result;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic             first_err_valid;
  logic [0:WIDTH-1] first_err_data;

  modport master (
    input  start, result,
    output idata, busy, done, pass, err_count, first_err_valid, first_err_data
  );

  modport slave (
    output start, result,
    input  idata, busy, done, pass, err_count, first_err_valid, first_err_data
  );
endinterface

// File: rtl/or_sweep_sequencer.sv
// or_sweep_sequencer: exhaustively sweeps a WIDTH-bit stimulus into the
// OR-gate lab DUT, checks each result against the reduction-OR of the
// vector after LATENCY extra cycles, counts mismatches (saturating),
// records the first failing vector and reports pass/done.
// Optional build macro STOP_ON_ERR_EN: end the sweep on the first mismatch.
`timescale 1ns/1ps
module or_sweep_sequencer #(
  parameter int WIDTH   = 10,
  parameter int LATENCY = 0,
  parameter int ERR_W   = 11
) (
  input logic       clk,
  input logic       rst,
  or_sweep_if.master bus
);

  localparam int CNT_W = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic [0:WIDTH-1] idata_q;
  logic [0:WIDTH-1] fed_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic             fev_q;
  logic [ERR_W-1:0] err_q;

  logic cmp_edge;
  logic mism;
  logic last_vec;
  logic sweep_end;

  // Saturating increment of the mismatch counter.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v == ERR_MAX) ? v : v + ERR_W'(1);
  endfunction

  assign cmp_edge = (state == RUN) && (wait_cnt == CNT_LAST);
  // Case-inequality so an X/Z result from the DUT is a mismatch.
  assign mism     = (bus.result !== (|idata_q));
  assign last_vec = &idata_q;

`ifdef STOP_ON_ERR_EN
  assign sweep_end = last_vec | mism;
`else
  assign sweep_end = last_vec;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: start only matters in IDLE, FINISH lasts one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (cmp_edge && sweep_end) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stimulus, wait counter, error bookkeeping and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idata_q  <= '0;
      fed_q    <= '0;
      wait_cnt <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      fev_q    <= 1'b0;
      err_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            idata_q  <= '0;
            wait_cnt <= '0;
            busy_q   <= 1'b1;
            pass_q   <= 1'b0;
            err_q    <= '0;
            fev_q    <= 1'b0;
          end
        end
        RUN: begin
          if (cmp_edge) begin
            if (mism) begin
              err_q <= sat_inc(err_q);
              if (!fev_q) begin
                fed_q <= idata_q;
                fev_q <= 1'b1;
              end
            end
            if (sweep_end) begin
              busy_q <= 1'b0;
              done_q <= 1'b1;
              pass_q <= (err_q == '0) && !mism;
            end else begin
              idata_q  <= idata_q + WIDTH'(1);
              wait_cnt <= '0;
            end
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        FINISH: done_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.idata           = idata_q;
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.pass            = pass_q;
  assign bus.err_count       = err_q;
  assign bus.first_err_valid = fev_q;
  assign bus.first_err_data  = fed_q;

endmodule

// File: tb/tb_or_sweep_sequencer.sv
// tb_or_sweep_sequencer: directed sweeps against several OR-gate DUT
// behaviours (correct, stuck-at-0, stuck-at-1, registered) with a
// per-cycle model of the main instance plus literal end-of-sweep checks.
`timescale 1ns/1ps
module tb_or_sweep_sequencer;

  localparam int W  = 10;
  localparam int NV = 1 << W;

  logic clk;
  logic rst;
  int   mode;      // 0 correct, 1 stuck-at-0, 2 registered, 3 stuck-at-1
  int   cyc;
  int   n_vec;
  int   n_bad;
  bit   model_on;
  int   sw_t;
  int   sw_mode;
  logic reg0;
  logic reg1;

  or_sweep_if #(.WIDTH(W), .ERR_W(11)) bus0 ();
  or_sweep_if #(.WIDTH(W), .ERR_W(11)) bus1 ();
  or_sweep_if #(.WIDTH(W), .ERR_W(4))  bus2 ();

  or_sweep_sequencer #(.WIDTH(W), .LATENCY(0), .ERR_W(11)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0.master));
  or_sweep_sequencer #(.WIDTH(W), .LATENCY(1), .ERR_W(11)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.master));
  or_sweep_sequencer #(.WIDTH(W), .LATENCY(0), .ERR_W(4)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2.master));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    reg0 <= |bus0.idata;
    reg1 <= |bus1.idata;
  end

  assign bus0.result = (mode == 0) ? (|bus0.idata) :
                       (mode == 1) ? 1'b0 :
                       (mode == 3) ? 1'b1 : reg0;
  assign bus1.result = reg1;
  assign bus2.result = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // DUT output for vector v under each combinational fault mode.
  function automatic bit fdut(input int m, input int v);
    case (m)
      1:       return 1'b0;
      3:       return 1'b1;
      default: return (v != 0);
    endcase
  endfunction

  // Mismatches among vectors 0..t-1.
  function automatic int cnt(input int m, input int t);
    int c = 0;
    for (int v = 0; v < t; v++) if (fdut(m, v) != (v != 0)) c++;
    return c;
  endfunction

  function automatic int first_idx(input int m);
    for (int v = 0; v < NV; v++) if (fdut(m, v) != (v != 0)) return v;
    return -1;
  endfunction

  // Number of compares in a sweep.
  function automatic int sweep_len(input int m);
`ifdef STOP_ON_ERR_EN
    int fi = first_idx(m);
    return (fi >= 0) ? fi + 1 : NV;
`else
    return NV + 0 * m;
`endif
  endfunction

  // Expected outputs t edges after the start edge: vector k compared at
  // edge k+1, so after edge t (t < n) idata = t and t compares are done.
  task automatic check_model();
    int n, c, tc, fi;
    n  = sweep_len(sw_mode);
    fi = first_idx(sw_mode);
    if (rst || sw_t < 0) begin
      chk("z_idata", 64'(bus0.idata), 64'd0);
      chk("z_busy",  64'(bus0.busy),  64'd0);
      chk("z_done",  64'(bus0.done),  64'd0);
      chk("z_pass",  64'(bus0.pass),  64'd0);
      chk("z_err",   64'(bus0.err_count), 64'd0);
      chk("z_fev",   64'(bus0.first_err_valid), 64'd0);
      chk("z_fed",   64'(bus0.first_err_data), 64'd0);
    end else begin
      tc = (sw_t < n) ? sw_t : n;
      c  = cnt(sw_mode, tc);
      chk("m_idata", 64'(bus0.idata), 64'((sw_t < n) ? sw_t : n - 1));
      chk("m_busy",  64'(bus0.busy),  64'(sw_t < n));
      chk("m_done",  64'(bus0.done),  64'(sw_t == n));
      chk("m_pass",  64'(bus0.pass),  64'((sw_t >= n) && (c == 0)));
      chk("m_err",   64'(bus0.err_count), 64'(c));
      chk("m_fev",   64'(bus0.first_err_valid), 64'(c > 0));
      if (c > 0) chk("m_fed", 64'(bus0.first_err_data), 64'(fi));
    end
  endtask

  // Compare process: check, then advance the sweep position for the next edge.
  always @(negedge clk) begin
    if (model_on) check_model();
    if (rst) sw_t = -1;
    else if ((sw_t < 0 || sw_t >= sweep_len(sw_mode) + 1) && bus0.start) begin
      sw_t    = 0;
      sw_mode = mode;
    end else if (sw_t >= 0) sw_t++;
  end

  task automatic pulse0(output int e0);
    @(posedge clk); #1 bus0.start = 1'b1;
    @(posedge clk); #1 bus0.start = 1'b0;
    e0 = cyc;
  endtask

  task automatic wait0(input int e0, output int lat);
    lat = -1;
    for (int i = 0; i < 2100; i++) begin
      @(posedge clk); #1;
      if (bus0.done) begin
        lat = cyc - e0;
        break;
      end
    end
  endtask

  initial begin
    int e0, lat, seen, l0, l1, l2;
    n_vec = 0; n_bad = 0; cyc = 0; model_on = 1'b1;
    sw_t = -1; sw_mode = 0; mode = 0;
    bus0.start = 1'b0; bus1.start = 1'b0; bus2.start = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_idata", 64'(bus0.idata), 64'd0);
    chk("rst_busy",  64'(bus0.busy), 64'd0);
    chk("rst_done",  64'(bus0.done), 64'd0);
    chk("rst_err",   64'(bus0.err_count), 64'd0);

    // Correct DUT, with a stray start pulse mid-sweep.
    mode = 0;
    pulse0(e0);
    repeat (499) @(posedge clk);
    #1 bus0.start = 1'b1;
    @(posedge clk); #1 bus0.start = 1'b0;
    wait0(e0, lat);
    chk("ok_lat",   64'(lat), 64'd1024);
    chk("ok_pass",  64'(bus0.pass), 64'd1);
    chk("ok_err",   64'(bus0.err_count), 64'd0);
    chk("ok_fev",   64'(bus0.first_err_valid), 64'd0);
    chk("ok_idata", 64'(bus0.idata), 64'h3ff);
    @(posedge clk); #1;
    chk("ok_done_drop", 64'(bus0.done), 64'd0);

    // Stuck-at-0 DUT.
    mode = 1;
    pulse0(e0);
    wait0(e0, lat);
`ifdef STOP_ON_ERR_EN
    chk("s0_lat", 64'(lat), 64'd2);
    chk("s0_err", 64'(bus0.err_count), 64'd1);
`else
    chk("s0_lat", 64'(lat), 64'd1024);
    chk("s0_err", 64'(bus0.err_count), 64'd1023);
`endif
    chk("s0_pass", 64'(bus0.pass), 64'd0);
    chk("s0_fed",  64'(bus0.first_err_data), 64'd1);

    // Stuck-at-1 DUT: only vector 0 mismatches.
    mode = 3;
    pulse0(e0);
    wait0(e0, lat);
`ifdef STOP_ON_ERR_EN
    chk("s1_lat",   64'(lat), 64'd1);
    chk("s1_idata", 64'(bus0.idata), 64'd0);
`else
    chk("s1_lat",   64'(lat), 64'd1024);
    chk("s1_idata", 64'(bus0.idata), 64'h3ff);
`endif
    chk("s1_err",  64'(bus0.err_count), 64'd1);
    chk("s1_fed",  64'(bus0.first_err_data), 64'd0);
    chk("s1_pass", 64'(bus0.pass), 64'd0);

    // Reset in the middle of a clean sweep, then a full clean sweep.
    mode = 0;
    pulse0(e0);
    repeat (300) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mr_busy",  64'(bus0.busy), 64'd0);
    chk("mr_idata", 64'(bus0.idata), 64'd0);
    chk("mr_err",   64'(bus0.err_count), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    seen = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (bus0.done) seen++;
    end
    chk("mr_no_done", 64'(seen), 64'd0);
    pulse0(e0);
    wait0(e0, lat);
    chk("mr2_lat",  64'(lat), 64'd1024);
    chk("mr2_pass", 64'(bus0.pass), 64'd1);

    // Registered DUTs: LATENCY=0 (too early) and LATENCY=1, plus a
    // stuck-at-0 DUT on a 4-bit error counter, all started together.
    model_on = 1'b0;
    mode = 2;
    @(posedge clk); #1;
    bus0.start = 1'b1; bus1.start = 1'b1; bus2.start = 1'b1;
    @(posedge clk); #1;
    bus0.start = 1'b0; bus1.start = 1'b0; bus2.start = 1'b0;
    e0 = cyc;
    l0 = -1; l1 = -1; l2 = -1;
    for (int i = 0; i < 2200 && (l0 < 0 || l1 < 0 || l2 < 0); i++) begin
      @(posedge clk); #1;
      if (bus0.done && l0 < 0) l0 = cyc - e0;
      if (bus1.done && l1 < 0) l1 = cyc - e0;
      if (bus2.done && l2 < 0) l2 = cyc - e0;
    end
`ifdef STOP_ON_ERR_EN
    chk("r0_lat", 64'(l0), 64'd1);
    chk("e4_lat", 64'(l2), 64'd2);
    chk("e4_err", 64'(bus2.err_count), 64'd1);
`else
    chk("r0_lat", 64'(l0), 64'd1024);
    chk("e4_lat", 64'(l2), 64'd1024);
    chk("e4_err", 64'(bus2.err_count), 64'd15);
`endif
    chk("r0_pass",  64'(bus0.pass), 64'd0);
    chk("r0_errnz", 64'(bus0.err_count != 0), 64'd1);
    chk("r1_lat",   64'(l1), 64'd2048);
    chk("r1_pass",  64'(bus1.pass), 64'd1);
    chk("r1_err",   64'(bus1.err_count), 64'd0);
    chk("e4_pass",  64'(bus2.pass), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
